// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of ALU and multiplier results into an
// in-order pending-write queue that drains one write per cycle into the
// register file, with two forwarding lookup ports over the pending entries.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_waddr,
    input  logic [DW-1:0]              alu_wdata,
    input  logic                       mul_valid,
    output logic                       mul_ready,
    input  logic [AW-1:0]              mul_waddr,
    input  logic [DW-1:0]              mul_wdata,
    input  logic                       wb_stall,
    output logic                       rf_wen,
    output logic [AW-1:0]              rf_waddr,
    output logic [DW-1:0]              rf_wdata,
    input  logic [AW-1:0]              fwd_raddr1,
    output logic                       fwd_hit1,
    output logic [DW-1:0]              fwd_data1,
    input  logic [AW-1:0]              fwd_raddr2,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]     pend_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MUL = 1'b1} src_e;

    src_e             last_grant;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    logic             full;
    logic             push;
    logic             pop;
    logic [AW-1:0]    in_waddr;
    logic [DW-1:0]    in_wdata;
    logic [PW-1:0]    idx;

    assign full     = (cnt == CW'(DEPTH));
    assign pend_cnt = cnt;

    // Round-robin grant: a lone valid source wins, a tie goes to the source
    // that did not win last. Nothing is accepted while full, even if the head
    // pops on the same edge.
    always_comb begin
        alu_ready = 1'b0;
        mul_ready = 1'b0;
        if (resetn && !full) begin
            if (alu_valid && mul_valid) begin
                if (last_grant == SRC_MUL) alu_ready = 1'b1;
                else                       mul_ready = 1'b1;
            end else begin
                alu_ready = alu_valid;
                mul_ready = mul_valid;
            end
        end
        in_waddr = alu_ready ? alu_waddr : mul_waddr;
        in_wdata = alu_ready ? alu_wdata : mul_wdata;
        // Writes to r0 are consumed but never occupy a queue slot.
        push     = (alu_ready || mul_ready) && (in_waddr != '0);
    end

    // Drain: the head entry is presented every cycle and pops when written.
    always_comb begin
        rf_wen   = (cnt != '0) && !wb_stall && resetn;
        rf_waddr = addr_mem[head];
        rf_wdata = data_mem[head];
        pop      = rf_wen;
    end

    // Control state: pointers, occupancy and round-robin history.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            last_grant <= SRC_MUL;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (alu_ready)      last_grant <= SRC_ALU;
            else if (mul_ready) last_grant <= SRC_MUL;
        end
    end

    // Queue storage: written at the tail on an accepted non-r0 result.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= in_waddr;
            data_mem[tail] <= in_wdata;
        end
    end

    // Forwarding: scan pending entries oldest to newest so the newest match
    // wins. Only registered queue contents are visible.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (resetn && (CW'(i) < cnt)) begin
                if (fwd_raddr1 != '0 && addr_mem[idx] == fwd_raddr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem[idx];
                end
                if (fwd_raddr2 != '0 && addr_mem[idx] == fwd_raddr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          alu_valid, alu_ready, mul_valid, mul_ready;
    logic [AW-1:0] alu_waddr, mul_waddr;
    logic [DW-1:0] alu_wdata, mul_wdata;
    logic          wb_stall, rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] fwd_raddr1, fwd_raddr2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0] pend_cnt;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_waddr(mul_waddr), .mul_wdata(mul_wdata),
        .wb_stall(wb_stall), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_raddr1(fwd_raddr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_raddr2(fwd_raddr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic [AW-1:0] f1;
        logic          e_ar;
        logic          e_mr;
        logic          e_wen;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [CW-1:0] e_cnt;
        logic          e_h1;
        logic [DW-1:0] e_d1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mul_valid = 1'b0; mul_waddr = '0; mul_wdata = '0;
    endtask

    task automatic alu_offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
        alu_valid = 1'b1; alu_waddr = a; alu_wdata = d;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Reference model state
    logic [AW+DW-1:0] mq [$];
    bit               lg_mul;

    initial begin
        logic ga, gm, ewen, eh1, eh2, keep_a, keep_m;
        logic [DW-1:0] ed1, ed2;

        resetn = 1'b0; wb_stall = 1'b0;
        fwd_raddr1 = 5'd3; fwd_raddr2 = '0;
        idle();
        alu_offer(5'd3, 32'h55); mul_valid = 1'b1; mul_waddr = 5'd4;
        tick();
        tick();
        chk("reset_alu_ready", 32'(alu_ready), 32'd0);
        chk("reset_mul_ready", 32'(mul_ready), 32'd0);
        chk("reset_rf_wen",    32'(rf_wen),    32'd0);
        chk("reset_fwd_hit1",  32'(fwd_hit1),  32'd0);
        chk("reset_pend_cnt",  32'(pend_cnt),  32'd0);
        resetn = 1'b1;
        idle();

        // Directed table: r3 latency, ALU/MUL alternation, r0 discard.
        tbl[0]  = '{1'b1, 5'd3, 32'h7D, 1'b0, 5'd0, 32'h0,  5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 32'h7D, 3'd1, 1'b1, 32'h7D};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd2, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22, 3'd1, 1'b1, 32'h22};
        tbl[5]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 3'd1, 1'b1, 32'h11};
        tbl[6]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd2, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22, 3'd1, 1'b1, 32'h22};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 3'd1, 1'b1, 32'h11};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b0, 32'h0};

        for (int i = 0; i < 11; i++) begin
            alu_valid = tbl[i].av; alu_waddr = tbl[i].aa; alu_wdata = tbl[i].ad;
            mul_valid = tbl[i].mv; mul_waddr = tbl[i].ma; mul_wdata = tbl[i].md;
            fwd_raddr1 = tbl[i].f1;
            #1;
            chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            chk($sformatf("tbl%0d_mul_ready", i), 32'(mul_ready), 32'(tbl[i].e_mr));
            chk($sformatf("tbl%0d_rf_wen", i),    32'(rf_wen),    32'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_pend_cnt", i),  32'(pend_cnt),  32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_fwd_hit1", i),  32'(fwd_hit1),  32'(tbl[i].e_h1));
            chk($sformatf("tbl%0d_fwd_data1", i), fwd_data1,      tbl[i].e_d1);
            if (tbl[i].e_wen) begin
                chk($sformatf("tbl%0d_rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_wa));
                chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata,      tbl[i].e_wd);
            end
            tick();
        end
        idle();

        // Fill under stall, fifth offer blocked, then ordered drain.
        do_reset();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_offer(AW'(4 + i), DW'(10 + i));
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(alu_ready), 32'd1);
            tick();
        end
        alu_offer(5'd9, 32'hE);
        #1;
        chk("full_pend_cnt", 32'(pend_cnt), 32'd4);
        chk("full_ready",    32'(alu_ready), 32'd0);
        chk("full_rf_wen",   32'(rf_wen),    32'd0);
        tick();
        wb_stall = 1'b0;
        #1;
        chk("full_pop_no_pass", 32'(alu_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("drain%0d_wen", i),   32'(rf_wen),   32'd1);
            chk($sformatf("drain%0d_waddr", i), 32'(rf_waddr), (i < 4) ? 32'(4 + i) : 32'd9);
            chk($sformatf("drain%0d_wdata", i), rf_wdata,      (i < 4) ? 32'(10 + i) : 32'hE);
            if (i == 1) chk("fifth_accepted", 32'(alu_ready), 32'd1);
            tick();
            if (i == 1) idle();
        end
        chk("drain_done_wen", 32'(rf_wen),   32'd0);
        chk("drain_done_cnt", 32'(pend_cnt), 32'd0);

        // Forwarding: newest of two writes to r8, misses on r0 and r9.
        wb_stall = 1'b1;
        alu_offer(5'd8, 32'h1); tick();
        alu_offer(5'd8, 32'h2); tick();
        idle();
        fwd_raddr1 = 5'd8; fwd_raddr2 = 5'd0;
        #1;
        chk("fwd_r8_hit",  32'(fwd_hit1),  32'd1);
        chk("fwd_r8_data", fwd_data1,      32'h2);
        chk("fwd_r0_hit",  32'(fwd_hit2),  32'd0);
        chk("fwd_r0_data", fwd_data2,      32'h0);
        fwd_raddr2 = 5'd9;
        #1;
        chk("fwd_r9_hit",  32'(fwd_hit2),  32'd0);
        chk("fwd_r9_data", fwd_data2,      32'h0);

        // Reset with three entries pending: nothing survives.
        alu_offer(5'd12, 32'hC); tick();
        idle();
        chk("pre_reset_cnt", 32'(pend_cnt), 32'd3);
        resetn = 1'b0;
        alu_offer(5'd13, 32'hD);
        #1;
        chk("in_reset_ready", 32'(alu_ready), 32'd0);
        chk("in_reset_wen",   32'(rf_wen),    32'd0);
        chk("in_reset_hit",   32'(fwd_hit1),  32'd0);
        tick();
        resetn = 1'b1; wb_stall = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_reset_cnt", 32'(pend_cnt), 32'd0);
            chk("post_reset_wen", 32'(rf_wen),   32'd0);
            tick();
        end

        // Randomized traffic against the reference queue model.
        do_reset();
        mq.delete();
        lg_mul = 1'b1;
        keep_a = 1'b0; keep_m = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!keep_a) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_waddr = AW'($urandom_range(0, 7));
                alu_wdata = $urandom;
            end
            if (!keep_m) begin
                mul_valid = ($urandom_range(0, 2) != 0);
                mul_waddr = AW'($urandom_range(0, 7));
                mul_wdata = $urandom;
            end
            wb_stall   = ($urandom_range(0, 2) == 0);
            fwd_raddr1 = AW'($urandom_range(0, 7));
            fwd_raddr2 = AW'($urandom_range(0, 7));
            #1;
            ga = 1'b0; gm = 1'b0;
            if (mq.size() < DEPTH) begin
                if (alu_valid && mul_valid) begin
                    ga = lg_mul;
                    gm = !lg_mul;
                end else begin
                    ga = alu_valid;
                    gm = mul_valid;
                end
            end
            ewen = (mq.size() != 0) && !wb_stall;
            eh1 = 1'b0; ed1 = '0; eh2 = 1'b0; ed2 = '0;
            foreach (mq[k]) begin
                if (fwd_raddr1 != 0 && mq[k][AW+DW-1:DW] == fwd_raddr1) begin eh1 = 1'b1; ed1 = mq[k][DW-1:0]; end
                if (fwd_raddr2 != 0 && mq[k][AW+DW-1:DW] == fwd_raddr2) begin eh2 = 1'b1; ed2 = mq[k][DW-1:0]; end
            end
            chk("rnd_alu_ready", 32'(alu_ready), 32'(ga));
            chk("rnd_mul_ready", 32'(mul_ready), 32'(gm));
            chk("rnd_rf_wen",    32'(rf_wen),    32'(ewen));
            chk("rnd_pend_cnt",  32'(pend_cnt),  32'(mq.size()));
            chk("rnd_fwd_hit1",  32'(fwd_hit1),  32'(eh1));
            chk("rnd_fwd_data1", fwd_data1,      ed1);
            chk("rnd_fwd_hit2",  32'(fwd_hit2),  32'(eh2));
            chk("rnd_fwd_data2", fwd_data2,      ed2);
            if (ewen) begin
                chk("rnd_rf_waddr", 32'(rf_waddr), 32'(mq[0][AW+DW-1:DW]));
                chk("rnd_rf_wdata", rf_wdata,      mq[0][DW-1:0]);
            end
            keep_a = alu_valid && !ga;
            keep_m = mul_valid && !gm;
            tick();
            if (ewen) void'(mq.pop_front());
            if (ga) begin
                lg_mul = 1'b0;
                if (alu_waddr != 0) mq.push_back({alu_waddr, alu_wdata});
            end
            if (gm) begin
                lg_mul = 1'b1;
                if (mul_waddr != 0) mq.push_back({mul_waddr, mul_wdata});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
